// File: rtl/opb_master_sequencer.sv
// Single-beat OPB bus master: takes one command at a time over a valid/ready port,
// arbitrates for the bus, runs the transfer (retry/timeout aware) and returns data plus status.
module opb_master_sequencer #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter int C_TIMEOUT    = 16,
    parameter int C_MAX_RETRY  = 3
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    // command port
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]     cmd_data,
    // response port
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [0:C_OPB_DWIDTH-1]     rsp_data,
    output logic [1:0]                  rsp_err,
    // OPB master outputs
    output logic                        M_request,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic                        M_seqAddr,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    // OPB inputs
    input  logic                        OPB_MGrant,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);

    localparam int BW = C_OPB_DWIDTH / 8;
    localparam int TW = $clog2(C_TIMEOUT + 1);
    localparam int RW = $clog2(C_MAX_RETRY + 2);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ACK   = 2'd1;
    localparam logic [1:0] ERR_RETRY = 2'd2;
    localparam logic [1:0] ERR_TOUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    rnw_q, rnw_d;
    logic [0:C_OPB_AWIDTH-1] addr_q, addr_d;
    logic [0:BW-1]           be_q, be_d;
    logic [0:C_OPB_DWIDTH-1] data_q, data_d;
    logic [RW-1:0]           retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]           tout_cnt_q, tout_cnt_d;
    logic [0:C_OPB_DWIDTH-1] rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_err_q, rsp_err_d;

    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    m_request_q, m_request_d;
    logic                    m_select_q, m_select_d;
    logic                    m_rnw_q, m_rnw_d;
    logic [0:C_OPB_AWIDTH-1] m_abus_q, m_abus_d;
    logic [0:BW-1]           m_be_q, m_be_d;
    logic [0:C_OPB_DWIDTH-1] m_dbus_q, m_dbus_d;

    // State register: reset clears everything at once, aborting any bus cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q     <= S_IDLE;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            data_q      <= '0;
            retry_cnt_q <= '0;
            tout_cnt_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            m_request_q <= 1'b0;
            m_select_q  <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_abus_q    <= '0;
            m_be_q      <= '0;
            m_dbus_q    <= '0;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            data_q      <= data_d;
            retry_cnt_q <= retry_cnt_d;
            tout_cnt_q  <= tout_cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            m_request_q <= m_request_d;
            m_select_q  <= m_select_d;
            m_rnw_q     <= m_rnw_d;
            m_abus_q    <= m_abus_d;
            m_be_q      <= m_be_d;
            m_dbus_q    <= m_dbus_d;
        end
    end

    // Next-state logic, including command latch, counters and response capture.
    always_comb begin
        state_d     = state_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        be_d        = be_q;
        data_d      = data_q;
        retry_cnt_d = retry_cnt_q;
        tout_cnt_d  = tout_cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rnw_d       = cmd_rnw;
                    addr_d      = cmd_addr;
                    be_d        = cmd_be;
                    data_d      = cmd_data;
                    retry_cnt_d = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (OPB_MGrant) begin
                    tout_cnt_d = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                // Acks outrank retry, and both outrank the local timeout.
                if (OPB_errAck) begin
                    rsp_err_d  = ERR_ACK;
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end else if (OPB_xferAck) begin
                    rsp_err_d  = ERR_OK;
                    rsp_data_d = rnw_q ? OPB_DBus : '0;
                    state_d    = S_RESP;
                end else if (OPB_retry) begin
                    if (retry_cnt_q < RW'(C_MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        rsp_err_d  = ERR_RETRY;
                        rsp_data_d = '0;
                        state_d    = S_RESP;
                    end
                end else if (!OPB_toutSup) begin
                    if (tout_cnt_q == TW'(C_TIMEOUT - 1)) begin
                        rsp_err_d  = ERR_TOUT;
                        rsp_data_d = '0;
                        state_d    = S_RESP;
                    end else begin
                        tout_cnt_d = tout_cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every bus signal leaves a flop.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        m_request_d = (state_d == S_REQ);
        m_select_d  = (state_d == S_XFER);
        m_rnw_d     = m_select_d & rnw_d;
        m_abus_d    = m_select_d ? addr_d : '0;
        m_be_d      = m_select_d ? be_d : '0;
        m_dbus_d    = (m_select_d && !rnw_d) ? data_d : '0;
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign M_request = m_request_q;
    assign M_select  = m_select_q;
    assign M_RNW     = m_rnw_q;
    assign M_seqAddr = 1'b0;
    assign M_ABus    = m_abus_q;
    assign M_BE      = m_be_q;
    assign M_DBus    = m_dbus_q;

endmodule

// File: tb/tb_opb_master_sequencer.sv
// Randomised bench for opb_master_sequencer: the bench plays arbiter and slave,
// a rule-level model predicts each response and a monitor checks it on handshake.
module tb_opb_master_sequencer;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int TOUT = 16;
    localparam int MAXR = 3;

    localparam int K_ACK      = 0;
    localparam int K_ERR      = 1;
    localparam int K_BOTH     = 2;
    localparam int K_RETRY    = 3;
    localparam int K_NONE     = 4;
    localparam int K_RETRYACK = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_be;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_err;
    logic          M_request, M_select, M_RNW, M_seqAddr;
    logic [AW-1:0] M_ABus;
    logic [BW-1:0] M_BE;
    logic [DW-1:0] M_DBus;
    logic          OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;
    logic [DW-1:0] OPB_DBus;

    always #5 clk = ~clk;

    opb_master_sequencer #(
        .C_OPB_AWIDTH(AW), .C_OPB_DWIDTH(DW), .C_TIMEOUT(TOUT), .C_MAX_RETRY(MAXR)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW), .M_seqAddr(M_seqAddr),
        .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
        .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
        .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup), .OPB_DBus(OPB_DBus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   hold_next = 1'b0;

    // per-command slave script: what the slave does on each select phase
    int att_kind[8];
    int att_w[8];
    bit att_sup[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit att_tout(input int i);
        return !att_sup[i] && (att_kind[i] == K_NONE || att_w[i] >= TOUT);
    endfunction

    // Reference: walk the slave script attempt by attempt and apply the status rules.
    function automatic void model(input logic rnw, input logic [DW-1:0] dbus,
                                  output int n_used, output rsp_t r);
        r.data = '0;
        r.err  = 2'd0;
        n_used = 0;
        for (int i = 0; i < 8; i++) begin
            n_used = i + 1;
            if (att_tout(i)) begin
                r.err = 2'd3;
                return;
            end
            if (att_kind[i] == K_ERR || att_kind[i] == K_BOTH) begin
                r.err = 2'd1;
                return;
            end
            if (att_kind[i] == K_ACK || att_kind[i] == K_RETRYACK) begin
                r.data = rnw ? dbus : '0;
                return;
            end
            if (att_kind[i] == K_RETRY && i == MAXR) begin
                r.err = 2'd2;
                return;
            end
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: got 0 required 1 after %0d cycles", n);
        end
    endtask

    task automatic run_cmd(input logic rnw, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                           input logic [DW-1:0] data, input logic [DW-1:0] dbus, input int gdelay);
        int   n_used;
        int   idx;
        bit   responded;
        rsp_t r;
        model(rnw, dbus, n_used, r);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_data  = data;
        exp_q.push_back(r);
        $display("cmd rnw=%0d addr=%08h be=%0h data=%08h attempts=%0d exp_err=%0d exp_data=%08h",
                 rnw, addr, be, data, n_used, r.err, r.data);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_rnw   = $urandom_range(0, 1);
        cmd_addr  = $urandom;
        cmd_be    = $urandom;
        cmd_data  = $urandom;
        for (int i = 0; i < n_used; i++) begin
            check("req_up", M_request, 1);
            check("sel_low_in_req", M_select, 0);
            repeat (gdelay) begin
                @(negedge clk);
                check("req_hold", M_request, 1);
            end
            OPB_MGrant = 1'b1;
            @(negedge clk);
            OPB_MGrant = 1'b0;
            check("sel_up", M_select, 1);
            check("req_drop", M_request, 0);
            idx = 0;
            responded = 1'b0;
            while (M_select && idx < 200) begin
                check("m_abus", M_ABus, addr);
                check("m_be", M_BE, be);
                check("m_rnw", M_RNW, rnw);
                check("m_dbus", M_DBus, rnw ? '0 : data);
                OPB_toutSup = att_sup[i];
                if (idx == att_w[i] && att_kind[i] != K_NONE) begin
                    OPB_xferAck = (att_kind[i] == K_ACK || att_kind[i] == K_BOTH ||
                                   att_kind[i] == K_RETRYACK);
                    OPB_errAck  = (att_kind[i] == K_ERR || att_kind[i] == K_BOTH);
                    OPB_retry   = (att_kind[i] == K_RETRY || att_kind[i] == K_RETRYACK);
                    OPB_DBus    = dbus;
                    @(negedge clk);
                    OPB_xferAck = 1'b0;
                    OPB_errAck  = 1'b0;
                    OPB_retry   = 1'b0;
                    responded   = 1'b1;
                    break;
                end
                OPB_DBus = $urandom;
                @(negedge clk);
                idx++;
            end
            OPB_toutSup = 1'b0;
            OPB_DBus    = $urandom;
            if (!responded) check("xfer_len", idx, att_tout(i) ? TOUT : att_w[i]);
            check("sel_end", M_select, 0);
            if (i == n_used - 1) check("rsp_latency", rsp_valid, 1);
        end
    endtask

    // Response monitor: random back-pressure, stability while stalled, scoreboard pop.
    initial begin
        bit            prev_valid = 1'b0;
        bit            prev_taken = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [1:0]    prev_err = '0;
        int            hold_cnt = 0;
        rsp_t          e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            check("seq_addr", M_seqAddr, 0);
            if (!M_select) begin
                check("idle_abus", M_ABus, 0);
                check("idle_rnw_be_dbus", {M_RNW, M_BE, M_DBus}, 0);
            end
            if (prev_valid && !prev_taken && rst_n) begin
                check("rsp_hold", rsp_valid, 1);
                check("rsp_stable_data", rsp_data, prev_data);
                check("rsp_stable_err", rsp_err, prev_err);
            end
            if (rsp_valid && !prev_valid && hold_next) begin
                hold_cnt  = 5;
                hold_next = 1'b0;
            end
            if (hold_cnt > 0) begin
                rsp_ready = 1'b0;
                hold_cnt--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            prev_taken = rsp_valid && rsp_ready;
            if (prev_taken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got err=%0d data=%08h required no response",
                             rsp_err, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp err=%0d data=%08h (expected err=%0d data=%08h)",
                             rsp_err, rsp_data, e.err, e.data);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_data", rsp_data, e.data);
                end
            end
            prev_valid = rsp_valid;
            prev_data  = rsp_data;
            prev_err   = rsp_err;
        end
    end

    task automatic clear_script();
        for (int i = 0; i < 8; i++) begin
            att_kind[i] = K_NONE;
            att_w[i]    = 0;
            att_sup[i]  = 1'b0;
        end
    endtask

    task automatic set_att(input int i, input int kind, input int w, input bit sup);
        att_kind[i] = kind;
        att_w[i]    = w;
        att_sup[i]  = sup;
    endtask

    initial begin
        int r;
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_data = '0;
        OPB_MGrant = 1'b0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0; OPB_retry = 1'b0;
        OPB_toutSup = 1'b0; OPB_DBus = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", {rsp_err, rsp_data}, 0);
        check("rst_m_ctrl", {M_request, M_select, M_RNW}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // directed cases
        clear_script(); set_att(0, K_ACK, 0, 1'b0);
        run_cmd(1'b0, 32'h0100_1000, 4'hF, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 0);
        clear_script(); set_att(0, K_ACK, 3, 1'b0);
        run_cmd(1'b1, 32'h0100_1004, 4'hF, 32'h5555_AAAA, 32'h1234_5678, 0);
        clear_script();
        for (int i = 0; i <= MAXR; i++) set_att(i, K_RETRY, 1, 1'b0);
        run_cmd(1'b0, 32'h0100_1008, 4'h3, 32'h0BAD_F00D, 32'h0, 1);
        clear_script(); set_att(0, K_NONE, 0, 1'b0);
        run_cmd(1'b1, 32'h0100_100C, 4'hF, 32'h0, 32'hFFFF_FFFF, 0);
        clear_script(); set_att(0, K_ACK, 40, 1'b1);
        run_cmd(1'b1, 32'h0100_1010, 4'hC, 32'h0, 32'hCAFE_0001, 2);
        clear_script(); set_att(0, K_ACK, TOUT - 1, 1'b0);
        run_cmd(1'b1, 32'h0100_1014, 4'hF, 32'h0, 32'h0BAD_CAFE, 0);
        hold_next = 1'b1;
        clear_script(); set_att(0, K_BOTH, 2, 1'b0);
        run_cmd(1'b1, 32'h0100_1018, 4'hF, 32'h0, 32'h7777_7777, 0);

        // randomised commands
        for (int c = 0; c < 60; c++) begin
            clear_script();
            r = $urandom_range(0, MAXR + 1);
            for (int i = 0; i < r; i++) set_att(i, K_RETRY, $urandom_range(0, 3), $urandom_range(0, 1));
            if (r <= MAXR) begin
                case ($urandom_range(0, 4))
                    0: att_kind[r] = K_ACK;
                    1: att_kind[r] = K_ERR;
                    2: att_kind[r] = K_BOTH;
                    3: att_kind[r] = K_NONE;
                    default: att_kind[r] = K_RETRYACK;
                endcase
                att_w[r]   = ($urandom_range(0, 3) == 0) ? TOUT - 2 + $urandom_range(0, 3)
                                                         : $urandom_range(0, 5);
                att_sup[r] = (att_kind[r] != K_NONE) && ($urandom_range(0, 3) == 0);
            end
            run_cmd($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 2));
        end

        // reset in the middle of a transfer
        wait_ready();
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0200_0000; cmd_be = 4'hF;
        cmd_data = 32'h1111_2222;
        @(negedge clk);
        cmd_valid = 1'b0;
        OPB_MGrant = 1'b1;
        @(negedge clk);
        OPB_MGrant = 1'b0;
        check("rst_test_sel_up", M_select, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_m_ctrl", {M_request, M_select, M_RNW}, 0);
        check("async_rst_abus", M_ABus, 0);
        check("async_rst_be_dbus", {M_BE, M_DBus}, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_cmd_ready", cmd_ready, 0);
        $display("reset asserted during XFER");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_cmd_ready", cmd_ready, 1);
        check("after_rst_req", M_request, 0);
        clear_script(); set_att(0, K_ACK, 1, 1'b0);
        run_cmd(1'b1, 32'h0300_0000, 4'h1, 32'h0, 32'h0000_0042, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d outstanding responses required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
